// File: rtl/exe_cmd_pkg.sv
// Shared ALU command encodings and STATUS bit positions for the control unit and execute stage.
package exe_cmd_pkg;

  typedef enum logic [3:0] {
    CmdNop = 4'b0000,
    CmdMov = 4'b0001,
    CmdAdd = 4'b0010,
    CmdAdc = 4'b0011,
    CmdSub = 4'b0100,
    CmdSbc = 4'b0101,
    CmdAnd = 4'b0110,
    CmdOrr = 4'b0111,
    CmdEor = 4'b1000,
    CmdMvn = 4'b1001
  } exe_cmd_e;

  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

  // Only the codes above (except NOP) produce a result and may update flags.
  function automatic logic is_legal_cmd(input logic [3:0] cmd);
    return (cmd >= 4'd1) && (cmd <= 4'd9);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result plus next NZCV; C and V pass through for logical ops and moves.
module alu_core
  import exe_cmd_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [3:0]        i_cmd,
  input  logic [3:0]        i_nzcv,   // current flags; C is the carry-in
  output logic [DATA_W-1:0] o_res,
  output logic [3:0]        o_nzcv
);

  logic [DATA_W:0]   w_ext;
  logic              w_cin;
  logic              w_c;
  logic              w_v;
  logic [DATA_W-1:0] w_res;

  // Decode the command and compute result, carry and overflow at DATA_W+1 bits.
  always_comb begin
    w_ext = '0;
    w_cin = 1'b0;
    w_res = '0;
    w_c   = i_nzcv[FlagC];
    w_v   = i_nzcv[FlagV];
    case (i_cmd)
      CmdMov: w_res = i_b;
      CmdMvn: w_res = ~i_b;
      CmdAdd, CmdAdc: begin
        w_cin = (i_cmd == CmdAdc) ? i_nzcv[FlagC] : 1'b0;
        w_ext = {1'b0, i_a} + {1'b0, i_b} + {{DATA_W{1'b0}}, w_cin};
        w_res = w_ext[DATA_W-1:0];
        w_c   = w_ext[DATA_W];
        w_v   = (i_a[DATA_W-1] == i_b[DATA_W-1]) && (w_res[DATA_W-1] != i_a[DATA_W-1]);
      end
      CmdSub, CmdSbc: begin
        // SBC subtracts the inverted carry as a borrow.
        w_cin = (i_cmd == CmdSbc) ? ~i_nzcv[FlagC] : 1'b0;
        w_ext = {1'b0, i_a} - {1'b0, i_b} - {{DATA_W{1'b0}}, w_cin};
        w_res = w_ext[DATA_W-1:0];
        w_c   = ~w_ext[DATA_W];
        w_v   = (i_a[DATA_W-1] != i_b[DATA_W-1]) && (w_res[DATA_W-1] != i_a[DATA_W-1]);
      end
      CmdAnd: w_res = i_a & i_b;
      CmdOrr: w_res = i_a | i_b;
      CmdEor: w_res = i_a ^ i_b;
      default: w_res = '0;
    endcase
  end

  assign o_res         = w_res;
  assign o_nzcv[FlagN] = w_res[DATA_W-1];
  assign o_nzcv[FlagZ] = (w_res == '0);
  assign o_nzcv[FlagC] = w_c;
  assign o_nzcv[FlagV] = w_v;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU, branch target adder, NZCV register and the EX/MEM pipeline register.
module execute_stage
  import exe_cmd_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMM_W  = 24
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_freeze,
  input  logic              i_flush,
  input  logic              i_valid_in,
  input  logic [3:0]        i_exe_cmd,
  input  logic              i_s,
  input  logic              i_b,
  input  logic              i_mem_r_en,
  input  logic              i_mem_w_en,
  input  logic              i_wb_en,
  input  logic [DATA_W-1:0] i_val_rn,
  input  logic [DATA_W-1:0] i_val_op2,
  input  logic [DATA_W-1:0] i_val_rm,
  input  logic [3:0]        i_dest,
  input  logic [DATA_W-1:0] i_pc_in,
  input  logic [IMM_W-1:0]  i_imm24,
  output logic              o_valid_out,
  output logic [DATA_W-1:0] o_alu_res,
  output logic [DATA_W-1:0] o_st_val,
  output logic [3:0]        o_dest_out,
  output logic              o_wb_en_out,
  output logic              o_mem_r_en_out,
  output logic              o_mem_w_en_out,
  output logic              o_br_taken,
  output logic [DATA_W-1:0] o_br_addr,
  output logic [3:0]        o_status
);

  logic [3:0]        r_status;
  logic              r_valid;
  logic              r_wb_en;
  logic              r_mem_r_en;
  logic              r_mem_w_en;
  logic              r_br_taken;
  logic [DATA_W-1:0] r_alu_res;
  logic [DATA_W-1:0] r_st_val;
  logic [DATA_W-1:0] r_br_addr;
  logic [3:0]        r_dest;

  logic [DATA_W-1:0] w_alu_res;
  logic [3:0]        w_nzcv;
  logic [DATA_W-1:0] w_imm_ext;
  logic [DATA_W-1:0] w_br_addr;
  logic              w_bubble;
  logic              w_load;
  logic              w_flag_en;

  alu_core #(
    .DATA_W(DATA_W)
  ) u_alu_core (
    .i_a    (i_val_rn),
    .i_b    (i_val_op2),
    .i_cmd  (i_exe_cmd),
    .i_nzcv (r_status),
    .o_res  (w_alu_res),
    .o_nzcv (w_nzcv)
  );

  assign w_imm_ext = {{(DATA_W - IMM_W){i_imm24[IMM_W-1]}}, i_imm24};
  assign w_br_addr = i_pc_in + (w_imm_ext << 2);

  // A bubble (flush or invalid input) overrides freeze; freeze alone holds everything.
  assign w_bubble  = i_flush | ~i_valid_in;
  assign w_load    = ~w_bubble & ~i_freeze;
  // Memory ops reuse S as the L bit, so they never touch the flags.
  assign w_flag_en = i_valid_in & i_s & ~i_b & ~i_mem_r_en & ~i_mem_w_en &
                     is_legal_cmd(i_exe_cmd) & ~i_freeze & ~i_flush;

  // Status register: updated only by valid, flag-setting ALU instructions.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_status <= '0;
    end else if (w_flag_en) begin
      r_status <= w_nzcv;
    end
  end

  // EX/MEM control bits: cleared by a bubble, held by freeze.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid    <= 1'b0;
      r_wb_en    <= 1'b0;
      r_mem_r_en <= 1'b0;
      r_mem_w_en <= 1'b0;
      r_br_taken <= 1'b0;
    end else if (w_bubble) begin
      r_valid    <= 1'b0;
      r_wb_en    <= 1'b0;
      r_mem_r_en <= 1'b0;
      r_mem_w_en <= 1'b0;
      r_br_taken <= 1'b0;
    end else if (!i_freeze) begin
      r_valid    <= 1'b1;
      r_wb_en    <= i_wb_en;
      r_mem_r_en <= i_mem_r_en;
      r_mem_w_en <= i_mem_w_en;
      r_br_taken <= i_b;
    end
  end

  // EX/MEM data fields: only loaded by a real, unfrozen instruction.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_alu_res <= '0;
      r_st_val  <= '0;
      r_br_addr <= '0;
      r_dest    <= '0;
    end else if (w_load) begin
      r_alu_res <= w_alu_res;
      r_st_val  <= i_val_rm;
      r_br_addr <= w_br_addr;
      r_dest    <= i_dest;
    end
  end

  assign o_valid_out    = r_valid;
  assign o_alu_res      = r_alu_res;
  assign o_st_val       = r_st_val;
  assign o_dest_out     = r_dest;
  assign o_wb_en_out    = r_wb_en;
  assign o_mem_r_en_out = r_mem_r_en;
  assign o_mem_w_en_out = r_mem_w_en;
  assign o_br_taken     = r_br_taken;
  assign o_br_addr      = r_br_addr;
  assign o_status       = r_status;

endmodule
